// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, opcode match values and branch decode for the fetch unit
package fetch_pkg;

    localparam int PC_W = 11;
    localparam int IR_W = 14;

    localparam logic [IR_W-1:0] NOP_WORD    = 14'h0000;

    localparam logic [IR_W-1:0] GOTO_MASK   = 14'h3800;
    localparam logic [IR_W-1:0] GOTO_MATCH  = 14'h2800;
    localparam logic [IR_W-1:0] CALL_MASK   = 14'h3800;
    localparam logic [IR_W-1:0] CALL_MATCH  = 14'h2000;
    localparam logic [IR_W-1:0] RETLW_MASK  = 14'h3C00;
    localparam logic [IR_W-1:0] RETLW_MATCH = 14'h3400;
    localparam logic [IR_W-1:0] RETURN_WORD = 14'h0008;
    localparam logic [IR_W-1:0] RETFIE_WORD = 14'h0009;

    typedef enum logic [1:0] {
        BR_NONE,
        BR_GOTO,
        BR_CALL,
        BR_RET
    } branch_e;

    // RETFIE has no interrupt side effects here, so it behaves exactly like RETURN.
    function automatic branch_e decode_branch(input logic [IR_W-1:0] ir);
        branch_e br;
        br = BR_NONE;
        if ((ir & GOTO_MASK) == GOTO_MATCH) begin
            br = BR_GOTO;
        end else if ((ir & CALL_MASK) == CALL_MATCH) begin
            br = BR_CALL;
        end else if ((ir == RETURN_WORD) || (ir == RETFIE_WORD) ||
                     ((ir & RETLW_MASK) == RETLW_MATCH)) begin
            br = BR_RET;
        end
        return br;
    endfunction

endpackage

// File: rtl/call_stack.sv
// rtl/call_stack.sv - circular return-address stack; occupancy check under FETCH_STACK_CHECK_EN
module call_stack
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] pop_data,
    output logic            err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [PTR_W-1:0] ptr_dec;

    // Explicit wrap so non power-of-two depths still behave circularly.
    assign ptr_inc  = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    assign ptr_dec  = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);

    // Top of stack sits just below the pointer; an empty pop reads the wrapped slot.
    assign pop_data = mem[ptr_dec];

    // Pointer moves on push/pop and never saturates, so overflow overwrites the oldest entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= ptr_inc;
        end else if (pop) begin
            ptr <= ptr_dec;
        end
    end

    // Entry storage needs no reset; stale contents are what an empty pop returns.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

`ifdef FETCH_STACK_CHECK_EN
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;

    // Occupancy saturates at 0..DEPTH; a push when full or pop when empty raises err for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            if (push) begin
                if (count == CNT_W'(DEPTH)) begin
                    err <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (pop) begin
                if (count == '0) begin
                    err <= 1'b1;
                end else begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC/IR fetch stage with branch handling; stack check under FETCH_STACK_CHECK_EN
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 11'h000,
    parameter int              STACK_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_in,
    input  logic            skip_in,
    input  logic [IR_W-1:0] Rom_data_in,
    output logic [PC_W-1:0] Rom_addr_out,
    output logic [IR_W-1:0] ir_out,
    output logic            ir_valid,
    output logic            stack_err
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [IR_W-1:0] ir_q;
    logic [IR_W-1:0] ir_d;
    logic            valid_q;
    logic            valid_d;
    logic            push;
    logic            pop;
    logic [PC_W-1:0] pop_data;
    branch_e         br;

    // Bubbles never decode, so back-to-back branches each pay their own bubble.
    assign br = valid_q ? decode_branch(ir_q) : BR_NONE;

    // Next PC/IR selection: stall > branch > skip > sequential.
    always_comb begin
        pc_d    = pc_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (!stall_in) begin
            case (br)
                BR_GOTO: begin
                    pc_d    = ir_q[PC_W-1:0];
                    ir_d    = NOP_WORD;
                    valid_d = 1'b0;
                end
                BR_CALL: begin
                    pc_d    = ir_q[PC_W-1:0];
                    ir_d    = NOP_WORD;
                    valid_d = 1'b0;
                    push    = 1'b1;
                end
                BR_RET: begin
                    pc_d    = pop_data;
                    ir_d    = NOP_WORD;
                    valid_d = 1'b0;
                    pop     = 1'b1;
                end
                default: begin
                    pc_d = pc_q + PC_W'(1);
                    if (skip_in && valid_q) begin
                        ir_d    = NOP_WORD;
                        valid_d = 1'b0;
                    end else begin
                        ir_d    = Rom_data_in;
                        valid_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // PC, IR and valid flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VECTOR;
            ir_q    <= NOP_WORD;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
        end
    end

    // While a CALL sits in IR the PC already points at the word after it.
    call_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q),
        .pop_data  (pop_data),
        .err       (stack_err)
    );

    assign Rom_addr_out = pc_q;
    assign ir_out       = ir_q;
    assign ir_valid     = valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

`ifdef FETCH_STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall_in;
    logic        skip_in;
    logic [13:0] Rom_data_in;
    logic [10:0] Rom_addr_out;
    logic [13:0] ir_out;
    logic        ir_valid;
    logic        stack_err;

    logic [13:0] rom [0:2047];

    typedef struct packed {
        logic [10:0] pc;
        logic [13:0] ir;
        logic        v;
        logic        err;
    } exp_t;

    exp_t  sb[$];
    int    total = 0;
    int    bad   = 0;
    int    idx   = 0;
    string scen  = "init";

    pc_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_in     (stall_in),
        .skip_in      (skip_in),
        .Rom_data_in  (Rom_data_in),
        .Rom_addr_out (Rom_addr_out),
        .ir_out       (ir_out),
        .ir_valid     (ir_valid),
        .stack_err    (stack_err)
    );

    assign Rom_data_in = rom[Rom_addr_out];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] dflt(input logic [10:0] a);
        return 14'h3000 | {4'b0000, a[9:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_rom();
        for (int a = 0; a < 2048; a++) rom[a] = dflt(11'(a));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        stall_in = 1'b0;
        skip_in  = 1'b0;
        #3;
        check({scen, " rst pc"},  Rom_addr_out, 11'h000);
        check({scen, " rst ir"},  ir_out, 14'h0000);
        check({scen, " rst v"},   ir_valid, 1'b0);
        check({scen, " rst err"}, stack_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idx   = 0;
    endtask

    task automatic step(input logic st, input logic sk, input logic [10:0] pc,
                        input logic [13:0] ir, input logic v, input logic e);
        exp_t x;
        stall_in = st;
        skip_in  = sk;
        sb.push_back('{pc, ir, v, e});
        @(posedge clk);
        #1;
        idx++;
        x = sb.pop_front();
        check($sformatf("%s#%0d pc", scen, idx),  Rom_addr_out, x.pc);
        check($sformatf("%s#%0d ir", scen, idx),  ir_out, x.ir);
        check($sformatf("%s#%0d v", scen, idx),   ir_valid, x.v);
        check($sformatf("%s#%0d err", scen, idx), stack_err, x.err);
    endtask

    initial begin
        logic [10:0] tgt;
        rst_n    = 1'b0;
        stall_in = 1'b0;
        skip_in  = 1'b0;

        // Sequential fetch, GOTO, skip flush and skip ignore cases
        scen = "seq";
        fill_rom();
        rom[0] = 14'h0103;
        rom[6] = 14'h0BA5;
        rom[7] = 14'h2805;
        do_reset();
        step(0, 0, 11'h001, 14'h0103, 1, 0);
        for (int k = 2; k <= 6; k++) step(0, 0, 11'(k), dflt(11'(k - 1)), 1, 0);
        step(0, 0, 11'h007, 14'h0BA5, 1, 0);
        step(0, 0, 11'h008, 14'h2805, 1, 0);
        step(0, 1, 11'h005, 14'h0000, 0, 0);
        step(0, 1, 11'h006, dflt(11'h005), 1, 0);
        step(0, 0, 11'h007, 14'h0BA5, 1, 0);
        step(0, 1, 11'h008, 14'h0000, 0, 0);
        step(0, 0, 11'h009, dflt(11'h008), 1, 0);

        // CALL/RETURN, CALL/RETLW, CALL/RETFIE
        scen = "call";
        fill_rom();
        rom[11'h000] = 14'h2810;
        rom[11'h010] = 14'h2100;
        rom[11'h100] = 14'h0008;
        rom[11'h011] = 14'h2200;
        rom[11'h200] = 14'h3455;
        rom[11'h012] = 14'h2300;
        rom[11'h300] = 14'h0009;
        do_reset();
        step(0, 0, 11'h001, 14'h2810, 1, 0);
        step(0, 0, 11'h010, 14'h0000, 0, 0);
        step(0, 0, 11'h011, 14'h2100, 1, 0);
        step(0, 0, 11'h100, 14'h0000, 0, 0);
        step(0, 0, 11'h101, 14'h0008, 1, 0);
        step(0, 0, 11'h011, 14'h0000, 0, 0);
        step(0, 0, 11'h012, 14'h2200, 1, 0);
        step(0, 0, 11'h200, 14'h0000, 0, 0);
        step(0, 0, 11'h201, 14'h3455, 1, 0);
        step(0, 0, 11'h012, 14'h0000, 0, 0);
        step(0, 0, 11'h013, 14'h2300, 1, 0);
        step(0, 0, 11'h300, 14'h0000, 0, 0);
        step(0, 0, 11'h301, 14'h0009, 1, 0);
        step(0, 0, 11'h013, 14'h0000, 0, 0);
        step(0, 0, 11'h014, dflt(11'h013), 1, 0);

        // Stall holding a GOTO, PC wrap, reset during a stalled branch
        scen = "stall";
        fill_rom();
        rom[11'h000] = 14'h2805;
        rom[11'h006] = 14'h2FFF;
        do_reset();
        step(0, 0, 11'h001, 14'h2805, 1, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 11'h001, 14'h2805, 1, 0);
        step(0, 0, 11'h005, 14'h0000, 0, 0);
        step(0, 0, 11'h006, dflt(11'h005), 1, 0);
        step(0, 0, 11'h007, 14'h2FFF, 1, 0);
        step(0, 0, 11'h7FF, 14'h0000, 0, 0);
        step(0, 0, 11'h000, dflt(11'h7FF), 1, 0);
        step(0, 0, 11'h001, 14'h2805, 1, 0);
        step(1, 0, 11'h001, 14'h2805, 1, 0);
        scen = "midrst";
        do_reset();
        step(0, 0, 11'h001, 14'h2805, 1, 0);
        step(0, 0, 11'h005, 14'h0000, 0, 0);

        // Nine nested CALLs then nine RETURNs: overflow overwrites oldest entry
        scen = "nest";
        fill_rom();
        for (int k = 0; k <= 8; k++) begin
            rom[11'(16 * k)]     = 14'h2000 | 14'(16 * (k + 1));
            rom[11'(16 * k + 1)] = 14'h0008;
        end
        rom[11'h090] = 14'h0008;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 11'(16 * (k - 1) + 1), 14'h2000 | 14'(16 * k), 1, 0);
            step(0, 0, 11'(16 * k), 14'h0000, 0, CHK && (k == 9));
        end
        step(0, 0, 11'h091, 14'h0008, 1, 0);
        for (int j = 1; j <= 9; j++) begin
            tgt = (j == 9) ? 11'h081 : 11'(16 * (9 - j) + 1);
            step(0, 0, tgt, 14'h0000, 0, CHK && (j == 9));
            step(0, 0, tgt + 11'h001, 14'h0008, 1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
